// File: rtl/hazard_flush_ctrl.sv
// Load-use bubble insertion and taken-branch flush sequencing for the 5-stage core.
// Latency: all control outputs are combinational from current state and inputs; state/counters update at the next edge.
// Backpressure: stalls PC and IF/ID for one cycle per load-use hazard; flushes never stall.
module hazard_flush_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } state_e;

  // Remaining BR_FLUSH cycles after the first flush cycle spent in RUN/LU_STALL.
  localparam logic [3:0] FL_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       fl_left_q, fl_left_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_hit;

  // Load-use hazard: the load in EX writes a register the ID instruction reads (x0 excluded).
  always_comb begin
    lu_hit = ex_MemRead && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state, counter updates and pipeline control outputs.
  always_comb begin
    state_d      = state_q;
    fl_left_d    = fl_left_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    case (state_q)
      BR_FLUSH: begin
        // Everything younger than the branch is a bubble here; events are ignored.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (fl_left_q == 4'd0) begin
          state_d = RUN;
        end else begin
          fl_left_d = fl_left_q - 4'd1;
        end
      end
      default: begin
        // RUN, LU_STALL and the illegal encoding all resolve back toward RUN.
        state_d = RUN;
        if (mem_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
          if (FLUSH_CYCLES > 1) begin
            fl_left_d = FL_INIT;
            state_d   = BR_FLUSH;
          end
        end else if (lu_hit && (state_q != LU_STALL)) begin
          // ID/EX already holds the bubble in LU_STALL, so the hit is masked there.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
          state_d     = LU_STALL;
        end
      end
    endcase

    // Keep the pipeline clear for the whole time reset is held.
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end
  end

  // State, flush counter and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fl_left_q   <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fl_left_q   <= fl_left_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctrl_state = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl: three instances (FLUSH_CYCLES=1, FLUSH_CYCLES=3, CNT_W=2)
// share one set of inputs; each task checks the instance relevant to its scenario.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_MemRead, mem_branch_taken;

  logic        a_pcw, a_ifw, a_iff, a_ief, a_emf;
  logic [1:0]  a_st;
  logic [15:0] a_sc, a_fc;
  logic        b_pcw, b_ifw, b_iff, b_ief, b_emf;
  logic [1:0]  b_st;
  logic [15:0] b_sc, b_fc;
  logic        c_pcw, c_ifw, c_iff, c_ief, c_emf;
  logic [1:0]  c_st;
  logic [1:0]  c_sc, c_fc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .mem_branch_taken(mem_branch_taken),
    .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_ief),
    .ex_mem_flush(a_emf), .ctrl_state(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc));

  hazard_flush_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .mem_branch_taken(mem_branch_taken),
    .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_ief),
    .ex_mem_flush(b_emf), .ctrl_state(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc));

  hazard_flush_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .mem_branch_taken(mem_branch_taken),
    .pc_write(c_pcw), .if_id_write(c_ifw), .if_id_flush(c_iff), .id_ex_flush(c_ief),
    .ex_mem_flush(c_emf), .ctrl_state(c_st), .stall_cnt(c_sc), .flush_cnt(c_fc));

  // Advance one clock; inputs change 2ns after the edge, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_MemRead = 1'b0; mem_branch_taken = 1'b0;
  endtask

  task automatic set_lu_hit();
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (a_pcw !== 1'b0) begin errors++; $display("FAIL rst_pc_write got %b exp 0", a_pcw); end
    checks++; if (a_ifw !== 1'b0) begin errors++; $display("FAIL rst_if_id_write got %b exp 0", a_ifw); end
    checks++; if ({a_iff, a_ief, a_emf} !== 3'b111) begin errors++; $display("FAIL rst_flushes got %b exp 111", {a_iff, a_ief, a_emf}); end
    tick();
    tick();
    checks++; if ({a_pcw, a_ifw, a_iff, a_ief, a_emf} !== 5'b00111) begin errors++; $display("FAIL rst_held got %b exp 00111", {a_pcw, a_ifw, a_iff, a_ief, a_emf}); end
    reset = 1'b0;
    #1;
    checks++; if (a_st !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", a_st); end
    checks++; if (a_sc !== 16'd0 || a_fc !== 16'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", a_sc, a_fc); end
    checks++; if ({a_pcw, a_ifw, a_iff, a_ief, a_emf} !== 5'b11000) begin errors++; $display("FAIL rst_release_outputs got %b exp 11000", {a_pcw, a_ifw, a_iff, a_ief, a_emf}); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu_hit();
    #1;
    checks++; if ({a_pcw, a_ifw, a_iff, a_ief, a_emf} !== 5'b00010) begin errors++; $display("FAIL lu_cycle0 got %b exp 00010", {a_pcw, a_ifw, a_iff, a_ief, a_emf}); end
    tick();
    #1;
    checks++; if (a_st !== 2'd1) begin errors++; $display("FAIL lu_cycle1_state got %0d exp 1", a_st); end
    checks++; if ({a_pcw, a_ifw, a_iff, a_ief, a_emf} !== 5'b11000) begin errors++; $display("FAIL lu_cycle1_masked got %b exp 11000", {a_pcw, a_ifw, a_iff, a_ief, a_emf}); end
    tick();
    idle_inputs();
    #1;
    checks++; if (a_st !== 2'd0) begin errors++; $display("FAIL lu_cycle2_state got %0d exp 0", a_st); end
    checks++; if (a_sc !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", a_sc); end
    tick();
    checks++; if (a_sc !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt_after got %0d exp 1", a_sc); end
  endtask

  task automatic test_x0();
    do_reset();
    ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    checks++; if ({a_pcw, a_ifw, a_ief} !== 3'b110) begin errors++; $display("FAIL x0_outputs got %b exp 110", {a_pcw, a_ifw, a_ief}); end
    tick();
    checks++; if (a_st !== 2'd0 || a_sc !== 16'd0) begin errors++; $display("FAIL x0_no_stall got state %0d cnt %0d exp 0 0", a_st, a_sc); end
    idle_inputs();
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_lu_hit();
    mem_branch_taken = 1'b1;
    #1;
    checks++; if ({a_pcw, a_ifw, a_iff, a_ief, a_emf} !== 5'b11111) begin errors++; $display("FAIL br_prio_outputs got %b exp 11111", {a_pcw, a_ifw, a_iff, a_ief, a_emf}); end
    tick();
    idle_inputs();
    #1;
    checks++; if (a_st !== 2'd0) begin errors++; $display("FAIL br_prio_state got %0d exp 0", a_st); end
    checks++; if (a_fc !== 16'd1 || a_sc !== 16'd0) begin errors++; $display("FAIL br_prio_counts got f%0d s%0d exp f1 s0", a_fc, a_sc); end
  endtask

  task automatic test_flush_multi();
    do_reset();
    mem_branch_taken = 1'b1;
    #1;
    checks++; if ({b_pcw, b_ifw, b_iff, b_ief, b_emf} !== 5'b11111 || b_st !== 2'd0) begin errors++; $display("FAIL fl3_cycle0 got %b st %0d exp 11111 st 0", {b_pcw, b_ifw, b_iff, b_ief, b_emf}, b_st); end
    for (int c = 1; c <= 2; c++) begin
      tick();
      set_lu_hit();
      mem_branch_taken = 1'b1;
      #1;
      checks++; if (b_st !== 2'd2) begin errors++; $display("FAIL fl3_state_c%0d got %0d exp 2", c, b_st); end
      checks++; if ({b_pcw, b_ifw, b_iff, b_ief, b_emf} !== 5'b11110) begin errors++; $display("FAIL fl3_outputs_c%0d got %b exp 11110", c, {b_pcw, b_ifw, b_iff, b_ief, b_emf}); end
    end
    tick();
    idle_inputs();
    #1;
    checks++; if (b_st !== 2'd0) begin errors++; $display("FAIL fl3_cycle3_state got %0d exp 0", b_st); end
    checks++; if (b_fc !== 16'd1 || b_sc !== 16'd0) begin errors++; $display("FAIL fl3_counts got f%0d s%0d exp f1 s0", b_fc, b_sc); end
  endtask

  task automatic test_saturate_and_abort();
    logic [1:0] exp_sc [5];
    exp_sc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_lu_hit();
      tick();
      idle_inputs();
      #1;
      checks++; if (c_sc !== exp_sc[i]) begin errors++; $display("FAIL sat_stall_cnt_%0d got %0d exp %0d", i, c_sc, exp_sc[i]); end
      tick();
    end
    set_lu_hit();
    tick();
    idle_inputs();
    #1;
    checks++; if (c_st !== 2'd1) begin errors++; $display("FAIL abort_pre_state got %0d exp 1", c_st); end
    reset = 1'b1;
    #1;
    checks++; if (c_st !== 2'd0 || c_sc !== 2'd0) begin errors++; $display("FAIL abort_reset got st %0d cnt %0d exp 0 0", c_st, c_sc); end
    checks++; if ({c_pcw, c_ifw, c_iff, c_ief, c_emf} !== 5'b00111) begin errors++; $display("FAIL abort_outputs got %b exp 00111", {c_pcw, c_ifw, c_iff, c_ief, c_emf}); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (c_st !== 2'd0 || c_pcw !== 1'b1) begin errors++; $display("FAIL abort_release got st %0d pcw %b exp 0 1", c_st, c_pcw); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_load_use();
    test_x0();
    test_branch_priority();
    test_flush_multi();
    test_saturate_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
